// File: rtl/ram_fifo_ctrl_pkg.sv
// rtl/ram_fifo_ctrl_pkg.sv - shared defaults for the RAM-backed FWFT FIFO
package ram_fifo_ctrl_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_DEPTH = 256;

endpackage

// File: rtl/ram_fifo_ctrl_sdcram.sv
// rtl/ram_fifo_ctrl_sdcram.sv - simple dual-port RAM, registered read port
// Contents are never cleared; the read port returns the word at addr_b one edge later.
module SdcRam #(
  parameter int DW    = 8,
  parameter int WORDS = 256
) (
  input  logic                     clk_a,
  input  logic                     wr_a,
  input  logic [$clog2(WORDS)-1:0] addr_a,
  input  logic [DW-1:0]            din_a,
  input  logic                     clk_b,
  input  logic [$clog2(WORDS)-1:0] addr_b,
  output logic [DW-1:0]            qout_b
);

  logic [DW-1:0] mem [WORDS];

  always_ff @(posedge clk_a) begin
    if (wr_a) begin
      mem[addr_a] <= din_a;
    end
  end

  always_ff @(posedge clk_b) begin
    qout_b <= mem[addr_b];
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - first-word-fall-through FIFO controller over SdcRam
// count includes the displayed head, so the writer can never reach the head slot.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] addr_b;
  logic [CW-1:0] unfetched;
  logic          push;
  logic          pop;
  logic          fetch;

  assign in_ready  = rst_n & (count != FULL);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign unfetched = count - CW'(out_valid);
  assign fetch     = (unfetched != '0) & (~out_valid | out_ready);

  // Without a fetch, keep re-reading the head so qout_b stays put during a stall.
  assign addr_b = fetch ? rd_ptr : rd_ptr - AW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (fetch) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (fetch) begin
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  SdcRam #(
    .DW    (DW),
    .WORDS (DEPTH)
  ) u_ram (
    .clk_a  (clk),
    .wr_a   (push),
    .addr_a (wr_ptr),
    .din_a  (in_data),
    .clk_b  (clk),
    .addr_b (addr_b),
    .qout_b (out_data)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - self-checking bench for ram_fifo_ctrl (DEPTH=4)
module tb_ram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [$clog2(DEPTH):0] count;

  ram_fifo_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: queue of stored words plus a flag saying whether the head is shown.
  logic [DW-1:0] q[$];
  bit            m_valid = 1'b0;

  typedef struct {
    logic          rn;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    int            e_cnt;
    logic          e_val;
    logic [DW-1:0] e_dat;
    logic          e_rdy;
  } vec_t;

  vec_t vt[13];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic step(input logic rn, input logic iv, input logic [DW-1:0] d, input logic ordy);
    bit m_push, m_pop, m_fetch, m_ready;
    int unf;
    rst_n     = rn;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #2;
    m_ready = rn && (q.size() < DEPTH);
    check("in_ready_pre", int'(in_ready), int'(m_ready));
    m_pop   = m_valid && ordy;
    m_push  = iv && m_ready;
    unf     = q.size() - int'(m_valid);
    m_fetch = (unf > 0) && (!m_valid || ordy);
    @(posedge clk);
    #1;
    if (!rn) begin
      q.delete();
      m_valid = 1'b0;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(d);
      if (m_fetch) m_valid = 1'b1;
      else if (m_pop) m_valid = 1'b0;
    end
    check("model_count", int'(count), q.size());
    check("model_valid", int'(out_valid), int'(m_valid));
    if (m_valid && q.size() > 0) check("model_data", int'(out_data), int'(q[0]));
    check("model_ready", int'(in_ready), int'(rn && (q.size() < DEPTH)));
  endtask

  function automatic vec_t mk(logic rn, logic iv, logic [DW-1:0] d, logic ordy,
                              int ec, logic ev, logic [DW-1:0] ed, logic er);
    vec_t v;
    v.rn = rn; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_cnt = ec; v.e_val = ev; v.e_dat = ed; v.e_rdy = er;
    return v;
  endfunction

  initial begin
    // Scenarios 1 and 2: single word latency, then fill / refuse / drain at DEPTH=4.
    vt[0]  = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    vt[1]  = mk(1, 1, 8'hA5, 1, 1, 0, 8'h00, 1);
    vt[2]  = mk(1, 0, 8'h00, 1, 1, 1, 8'hA5, 1);
    vt[3]  = mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1);
    vt[4]  = mk(1, 1, 8'h01, 0, 1, 0, 8'h00, 1);
    vt[5]  = mk(1, 1, 8'h02, 0, 2, 1, 8'h01, 1);
    vt[6]  = mk(1, 1, 8'h03, 0, 3, 1, 8'h01, 1);
    vt[7]  = mk(1, 1, 8'h04, 0, 4, 1, 8'h01, 0);
    vt[8]  = mk(1, 1, 8'h05, 0, 4, 1, 8'h01, 0);
    vt[9]  = mk(1, 0, 8'h00, 1, 3, 1, 8'h02, 1);
    vt[10] = mk(1, 0, 8'h00, 1, 2, 1, 8'h03, 1);
    vt[11] = mk(1, 0, 8'h00, 1, 1, 1, 8'h04, 1);
    vt[12] = mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1);

    for (int i = 0; i < 13; i++) begin
      step(vt[i].rn, vt[i].iv, vt[i].d, vt[i].ordy);
      check($sformatf("vec%0d_count", i), int'(count), vt[i].e_cnt);
      check($sformatf("vec%0d_valid", i), int'(out_valid), int'(vt[i].e_val));
      if (vt[i].e_val) check($sformatf("vec%0d_data", i), int'(out_data), int'(vt[i].e_dat));
      check($sformatf("vec%0d_ready", i), int'(in_ready), int'(vt[i].e_rdy));
    end

    // Scenario 3: streaming across wrap keeps two entries in flight and pops every cycle.
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step(1, 1, 8'(8'h10 + i), 1);
      if (i >= 1) begin
        check("stream_count", int'(count), 2);
        check("stream_valid", int'(out_valid), 1);
      end
    end
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 1);
    check("stream_drained", int'(count), 0);

    // Scenario 5: reset with three entries held, then a fresh word must come out first.
    for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h70 + i), 0);
    check("pre_rst_count", int'(count), 3);
    step(0, 0, 8'h00, 0);
    check("rst_count", int'(count), 0);
    check("rst_valid", int'(out_valid), 0);
    step(1, 1, 8'h3C, 1);
    check("post_rst_valid", int'(out_valid), 0);
    step(1, 0, 8'h00, 0);
    check("post_rst_valid2", int'(out_valid), 1);
    check("post_rst_data", int'(out_data), 8'h3C);
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    check("post_rst_empty", int'(count), 0);

    // Scenario 6: pop at full refuses the concurrent push; it lands the next cycle.
    for (int i = 0; i < DEPTH; i++) step(1, 1, 8'(8'hC0 + i), 0);
    check("full_count", int'(count), DEPTH);
    check("full_ready", int'(in_ready), 0);
    step(1, 1, 8'hEE, 1);
    check("full_pop_count", int'(count), DEPTH - 1);
    check("full_pop_head", int'(out_data), 8'hC1);
    step(1, 1, 8'hEE, 0);
    check("full_refill_count", int'(count), DEPTH);
    for (int i = 0; i < DEPTH + 2; i++) step(1, 0, 8'h00, 1);
    check("full_drained", int'(count), 0);

    // Scenario 4: random traffic at 50% on each side against the reference queue.
    for (int i = 0; i < 10000; i++) begin
      step(1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
